// File: rtl/ram_sync_bank.sv
// ram_sync_bank: synchronous single-port RAM bank with a valid/ready request port.
//
// After every reset a sequencer zero-fills all DEPTH words, one word per cycle,
// before the port opens. In RUN the bank accepts one request per cycle with no
// back-pressure. Writes honour per-byte enables. Reads return data RD_LAT
// cycles (1 or 2) after accept.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake; accept = valid && ready
//   req_we                1 = write, 0 = read
//   req_addr              word address (full ADDR_W bits compared against DEPTH)
//   req_wdata, req_be     write data and byte enables (be ignored on reads)
//   rsp_valid             one-cycle read response pulse
//   rsp_rdata             read data, held between responses
//   rsp_err               qualifies rsp_valid: read address was out of range
//   wr_err                one-cycle pulse: accepted write was out of range
//   init_done             zero-fill complete
module ram_sync_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                wr_err,
   output logic                init_done
);
   localparam int                NUM_LANES = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {CLEAR, RUN} state_t;

   typedef struct packed {
      logic                      we;
      logic [ADDR_W-1:0]         addr;
      logic [NUM_LANES-1:0][7:0] wdata;
      logic [NUM_LANES-1:0]      be;
   } req_t;

   state_t                    state;
   logic [ADDR_W-1:0]         cnt;
   req_t                      req;
   logic                      acc, wr_acc, rd_acc, in_range, clearing;
   logic [NUM_LANES-1:0]      lane_we;
   logic [ADDR_W-1:0]         lane_addr;
   logic [NUM_LANES-1:0][7:0] lane_wdata;
   logic [NUM_LANES-1:0][7:0] lane_rdata;
   // vld_pipe[k] / err_pipe[k] describe the read accepted k cycles ago
   logic [RD_LAT:1]           vld_pipe, err_pipe;

   assign req = {req_we, req_addr, req_wdata, req_be};

   // req_ready is only ever high in RUN, so acc already implies RUN; the
   // rst_n term keeps a request at a reset edge from touching memory.
   assign acc      = rst_n && req_valid && req_ready;
   assign wr_acc   = acc && req.we;
   assign rd_acc   = acc && !req.we;
   assign in_range = {1'b0, req.addr} < DEPTH_W;
   assign clearing = rst_n && (state == CLEAR);

   // The fill sequencer and the request port share the single write port.
   always_comb begin
      lane_we    = '0;
      lane_addr  = req.addr;
      lane_wdata = req.wdata;
      if (clearing) begin
         lane_we    = '1;
         lane_addr  = cnt;
         lane_wdata = '0;
      end else if (wr_acc && in_range) begin
         lane_we = req.be;
      end
   end

   // Fill sequencer: CLEAR writes one word per cycle, RUN is terminal.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= CLEAR;
         cnt       <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (cnt == LAST_ADDR) begin
                  state     <= RUN;
                  cnt       <= '0;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               req_ready <= 1'b1;
               init_done <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // Response tracking; reset flushes anything in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         wr_err   <= 1'b0;
      end else begin
         vld_pipe[1] <= rd_acc;
         err_pipe[1] <= rd_acc && !in_range;
         for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            err_pipe[k] <= err_pipe[k-1];
         end
         wr_err <= wr_acc && !in_range;
      end
   end

   genvar gi;
   for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      ram_sync_bank_lane #(
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (lane_we[gi]),
         .wr_addr (lane_addr),
         .wr_data (lane_wdata[gi]),
         .rd_en   (rd_acc),
         .rd_ok   (in_range),
         .rd_addr (req.addr),
         .rd_data (lane_rdata[gi])
      );
   end

   // Lane read registers already hold their value between reads; the second
   // stage likewise only loads when a response moves through it.
   if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_q;
      always_ff @(posedge clk) begin
         if (!rst_n)
            out_q <= '0;
         else if (vld_pipe[1])
            out_q <= lane_rdata;
      end
      assign rsp_rdata = out_q;
   end else begin : g_lat1
      assign rsp_rdata = lane_rdata;
   end

   assign rsp_valid = vld_pipe[RD_LAT];
   assign rsp_err   = err_pipe[RD_LAT];
endmodule

// ram_sync_bank_lane: one byte lane of storage with a registered read port.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset (read register only)
//   wr_en/addr/data    byte write
//   rd_en, rd_ok       read strobe; rd_ok=0 returns zero instead of memory
//   rd_addr, rd_data   read address and registered read byte
module ram_sync_bank_lane #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   input  logic              rd_ok,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);
   logic [7:0] mem [DEPTH];

   // Storage is not reset; the fill sequencer provides defined contents.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= rd_ok ? mem[rd_addr] : 8'h00;
   end
endmodule

// File: tb/tb_ram_sync_bank.sv
// Directed bench for ram_sync_bank. Three instances share one stimulus bus:
//   a: defaults (DEPTH 64, RD_LAT 1)
//   b: RD_LAT 2
//   c: DEPTH 48 (out-of-range handling)
module tb_ram_sync_bank;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [5:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;

   logic        rdy_a, vld_a, err_a, werr_a, done_a;
   logic        rdy_b, vld_b, err_b, werr_b, done_b;
   logic        rdy_c, vld_c, err_c, werr_c, done_c;
   logic [31:0] dat_a, dat_b, dat_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_sync_bank u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(vld_a), .rsp_rdata(dat_a), .rsp_err(err_a), .wr_err(werr_a),
      .init_done(done_a));

   ram_sync_bank #(.RD_LAT(2)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(vld_b), .rsp_rdata(dat_b), .rsp_err(err_b), .wr_err(werr_b),
      .init_done(done_b));

   ram_sync_bank #(.DEPTH(48)) u_c (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_c),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(vld_c), .rsp_rdata(dat_c), .rsp_err(err_c), .wr_err(werr_c),
      .init_done(done_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle bus carries junk that must be ignored while req_valid is low.
   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b1;
      req_addr  = 6'd0;
      req_wdata = 32'hFFFF_FFFF;
      req_be    = 4'hF;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy_a"}, rdy_a, 0);  chk({tag, "_rdy_b"}, rdy_b, 0);
      chk({tag, "_rdy_c"}, rdy_c, 0);  chk({tag, "_vld_a"}, vld_a, 0);
      chk({tag, "_vld_b"}, vld_b, 0);  chk({tag, "_vld_c"}, vld_c, 0);
      chk({tag, "_dat_a"}, dat_a, 0);  chk({tag, "_dat_b"}, dat_b, 0);
      chk({tag, "_err_a"}, err_a, 0);  chk({tag, "_werr_c"}, werr_c, 0);
      chk({tag, "_done_a"}, done_a, 0); chk({tag, "_done_c"}, done_c, 0);
   endtask

   // Release reset and count the cycles each bank keeps req_ready low.
   task automatic release_and_count(input string tag);
      int na = 0;
      int nc = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (!rdy_a) na++;
         if (!rdy_c) nc++;
         tick();
      end
      chk({tag, "_clear_cycles_a"}, na, 64);
      chk({tag, "_clear_cycles_c"}, nc, 48);
      chk({tag, "_done_a"}, done_a, 1);
      chk({tag, "_rdy_b"}, rdy_b, 1);
   endtask

   task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] be);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr;
      req_wdata = data;
      req_be    = be;
      tick();
      idle();
   endtask

   // Single read: a and c respond one cycle after accept, b one cycle later.
   task automatic rd(input string tag, input logic [5:0] addr, input logic [31:0] exp);
      logic oor_c;
      oor_c     = (addr >= 6'd48);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addr;
      req_be    = 4'h0;
      tick();
      idle();
      chk({tag, "_vld_a"}, vld_a, 1);
      chk({tag, "_dat_a"}, dat_a, exp);
      chk({tag, "_err_a"}, err_a, 0);
      chk({tag, "_vld_c"}, vld_c, 1);
      chk({tag, "_err_c"}, err_c, oor_c);
      chk({tag, "_dat_c"}, dat_c, oor_c ? 32'h0 : exp);
      chk({tag, "_vld_b_early"}, vld_b, 0);
      tick();
      chk({tag, "_vld_b"}, vld_b, 1);
      chk({tag, "_dat_b"}, dat_b, exp);
      chk({tag, "_err_b"}, err_b, 0);
      chk({tag, "_vld_a_pulse"}, vld_a, 0);
   endtask

   initial begin
      idle();
      repeat (3) tick();
      chk_reset("reset");

      release_and_count("init");

      rd("rd0", 6'd0, 32'h0);
      rd("rd31", 6'd31, 32'h0);
      rd("rd63", 6'd63, 32'h0);

      wr(6'd1, 32'h0000_0001, 4'hF);
      wr(6'd2, 32'h0000_0000, 4'hF);
      rd("raw1", 6'd1, 32'h0000_0001);
      rd("raw2", 6'd2, 32'h0000_0000);

      wr(6'd5, 32'hAABB_CCDD, 4'hF);
      wr(6'd5, 32'h1122_3344, 4'b0101);
      rd("be5", 6'd5, 32'hAA22_CC44);

      wr(6'd7, 32'h1234_5678, 4'h0);
      rd("be0", 6'd7, 32'h0);

      // back-to-back reads
      wr(6'd1, 32'h10, 4'hF);
      wr(6'd2, 32'h20, 4'hF);
      wr(6'd3, 32'h30, 4'hF);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'd1;
      tick();
      chk("burst_a1", dat_a, 32'h10);
      chk("burst_b_wait", vld_b, 0);
      req_addr = 6'd2;
      tick();
      chk("burst_a2", dat_a, 32'h20);
      chk("burst_bv1", vld_b, 1);
      chk("burst_b1", dat_b, 32'h10);
      req_addr = 6'd3;
      tick();
      chk("burst_a3", dat_a, 32'h30);
      chk("burst_b2", dat_b, 32'h20);
      idle();
      tick();
      chk("burst_a_end", vld_a, 0);
      chk("burst_bv3", vld_b, 1);
      chk("burst_b3", dat_b, 32'h30);
      tick();
      chk("burst_b_end", vld_b, 0);
      repeat (3) tick();
      chk("hold_a", dat_a, 32'h30);
      chk("hold_b", dat_b, 32'h30);

      // out-of-range write on c only
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 6'd50;
      req_wdata = 32'hDEAD_BEEF;
      req_be    = 4'hF;
      tick();
      idle();
      chk("wr50_werr_c", werr_c, 1);
      chk("wr50_werr_a", werr_a, 0);
      tick();
      chk("wr50_werr_c_pulse", werr_c, 0);
      rd("rd50", 6'd50, 32'hDEAD_BEEF);
      rd("rd47", 6'd47, 32'h0);
      rd("alias2", 6'd2, 32'h20);

      // reset one cycle after a read accept
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'd5;
      tick();
      idle();
      rst_n = 1'b0;
      chk("midrst_pre_vld_a", vld_a, 1);
      tick();
      chk_reset("midrst");
      tick();
      chk("midrst_vld_b_late", vld_b, 0);
      release_and_count("reinit");
      rd("after_rst5", 6'd5, 32'h0);
      rd("after_rst0", 6'd0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ram_sync_bank.md
Name: ram_sync_bank

Overview:
- Parametrised synchronous single-port RAM, successor to the tristate, enable/rw-strobed RAM.
- Separate write and read data buses; no tristate.
- Valid/ready request port with byte write enables and configurable read latency (1 or 2).
- After every reset, an internal sequencer zero-fills all of memory, so contents are deterministic. Serves as the general-purpose storage bank for lab datapaths.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 6, address width in bits.
- DEPTH, 64, number of words; 1 <= DEPTH <= 2^ADDR_W (need not be a power of two).
- RD_LAT, 1, read latency in cycles from request accept to rsp_valid; legal values 1 or 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; bit i gates byte [8i+7:8i]. Ignored on reads.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_rdata  out  DATA_W  read data; held until the next rsp_valid.
- rsp_err  out  1  qualifies rsp_valid; read address was >= DEPTH.
- wr_err  out  1  one-cycle pulse; accepted write had address >= DEPTH.
- init_done  out  1  high once the zero-fill is complete.

Behaviour:
- Reset (rst_n low at a clock edge):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, init_done=0.
  - Read pipeline flushed; clear counter set to 0; FSM enters CLEAR.
  - Reset asserted mid-operation, including mid-CLEAR, discards in-flight reads (no rsp_valid) and restarts the fill from address 0.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt==DEPTH-1 is written, go to RUN. Takes exactly DEPTH cycles after reset release. req_ready=0 throughout.
  - RUN: init_done=1 and req_ready=1 every cycle; the bank has no back-pressure. No other state is reachable except via reset.
- Write accept:
  - mem[addr] bytes with req_be[i]=1 are updated at that clock edge; other bytes are unchanged.
  - be=0 is a legal no-op.
  - addr >= DEPTH: memory is unchanged and wr_err pulses in the next cycle.
- Read accept at edge T:
  - RD_LAT=1: rsp_valid=1 and rsp_rdata=mem[addr] during cycle T+1.
  - RD_LAT=2: the data passes through an additional output register, so rsp_valid is high in cycle T+2.
  - Back-to-back reads give one response per cycle, in order.
  - addr >= DEPTH: rsp_valid pulses at the normal latency with rsp_err=1 and rsp_rdata=0.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data; a single-port design cannot accept both in one cycle.
- No simultaneous read/write exists on one port; req_we selects exactly one.
- rsp_rdata holds its last value when rsp_valid=0. rsp_err is meaningful only with rsp_valid.
- Address compare uses the full ADDR_W bits; no wrap-around modulo DEPTH.
- X on req_* while req_valid=0 must not affect state.

Test Plan:
- Reset release, DEPTH=64 -> req_ready=0 for exactly 64 cycles, then init_done=1 and req_ready=1. Reading addr 0, 31 and 63 returns 0x00000000.
- Write addr=1 data=0x00000001 be=4'hF, then write addr=2 data=0x0, then read addr=1 -> rsp_valid one cycle after accept with 0x00000001. Read addr=2 -> 0x00000000.
- Write addr=5 data=0xAABBCCDD be=4'hF, then write addr=5 data=0x11223344 be=4'b0101, then read addr=5 -> 0xAA22CC44.
- RD_LAT=2: back-to-back reads of addr 1,2,3 holding 0x10,0x20,0x30 -> rsp_valid in cycles T+2..T+4 with 0x10,0x20,0x30 in order.
- DEPTH=48, ADDR_W=6: write addr=50 -> wr_err pulse and no memory change. Read addr=50 -> rsp_valid=1, rsp_err=1, rsp_rdata=0. Read addr=47 -> rsp_err=0.
- Issue a read, assert rst_n=0 in the following cycle -> no rsp_valid, all outputs at reset values. After release, 64 CLEAR cycles occur and previously written addr 5 reads 0.
